// File: rtl/fetch_unit_pkg.sv
// Shared widths, instruction field positions and fetch FSM states for the
// fetch stage.
package fetch_unit_pkg;

  localparam int ADDR_W  = 6;
  localparam int INSTR_W = 23;

  localparam int OPC_MSB = 22;
  localparam int OPC_LSB = 20;
  localparam int RD_MSB  = 19;
  localparam int RD_LSB  = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: a redirect load beats an increment, and the increment
// wraps naturally at the top of the address space.
module fetch_unit_pc_reg
  import fetch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  // NOTE: sequential state is written with non-blocking assignments only,
  // so every register samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: drives the instruction-memory address, captures the word into
// the decode slot, and hands it to decode over a valid/ready handshake.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] LAST_ADDR = 6'h3F,
  parameter int                CNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  im_address,
  input  logic [INSTR_W-1:0] im_code,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [2:0]         out_opcode,
  output logic [3:0]         out_rd,
  output logic [15:0]        out_imm,
  output logic               done,
  output logic [CNT_W-1:0]   fetch_count
);

  state_t             state, state_next;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] ir;
  logic               slot_free;
  logic               capture;
  logic               flush;
  logic               drain;

  assign slot_free = !out_valid || out_ready;

  fetch_unit_pc_reg u_pc_reg (
    .clk    (clk),
    .reset  (reset),
    .load   (flush),
    .inc    (capture),
    .target (redirect_target),
    .pc     (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    flush      = 1'b0;
    drain      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        // A redirect flushes the slot even when decode is accepting it.
        if (redirect_valid) begin
          flush = 1'b1;
        end else if (slot_free) begin
          capture = 1'b1;
          if (pc == LAST_ADDR) state_next = DONE;
        end
      end
      DONE: begin
        if (redirect_valid) begin
          flush      = 1'b1;
          state_next = RUN;
        end else if (out_ready) begin
          drain = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir          <= '0;
      out_pc      <= '0;
      out_valid   <= 1'b0;
      fetch_count <= '0;
    end else if (flush || drain) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      ir        <= im_code;
      out_pc    <= pc;
      out_valid <= 1'b1;
      if (fetch_count != {CNT_W{1'b1}}) fetch_count <= fetch_count + CNT_W'(1);
    end
  end

  assign im_address = pc;
  assign done       = (state == DONE);
  assign out_opcode = ir[OPC_MSB:OPC_LSB];
  assign out_rd     = ir[RD_MSB:RD_LSB];
  assign out_imm    = ir[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances share stimulus, one ending at
// word 4 and one ending at word 2 for the address-wrap run.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        redirect_valid;
  logic [5:0]  redirect_target;
  logic        out_ready;

  logic [5:0]  a_addr, b_addr;
  logic [22:0] a_code, b_code;
  logic        a_valid, b_valid;
  logic [5:0]  a_pc, b_pc;
  logic [2:0]  a_opc, b_opc;
  logic [3:0]  a_rd, b_rd;
  logic [15:0] a_imm, b_imm;
  logic        a_done, b_done;
  logic [7:0]  a_cnt, b_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [22:0] mem_word(input logic [5:0] a);
    if (a <= 6'd4) return {3'b000, a[3:0], 16'(a)};
    return 23'h0;
  endfunction

  assign a_code = mem_word(a_addr);
  assign b_code = mem_word(b_addr);

  fetch_unit #(.LAST_ADDR(6'h04), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .im_address(a_addr), .im_code(a_code),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(a_valid), .out_ready(out_ready), .out_pc(a_pc),
    .out_opcode(a_opc), .out_rd(a_rd), .out_imm(a_imm),
    .done(a_done), .fetch_count(a_cnt)
  );

  fetch_unit #(.LAST_ADDR(6'h02), .CNT_W(8)) dut_w (
    .clk(clk), .reset(reset), .start(start),
    .im_address(b_addr), .im_code(b_code),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(b_valid), .out_ready(out_ready), .out_pc(b_pc),
    .out_opcode(b_opc), .out_rd(b_rd), .out_imm(b_imm),
    .done(b_done), .fetch_count(b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next one.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_a(input string tag, input logic v, input logic [5:0] pc,
                         input logic [5:0] addr, input logic [7:0] cnt, input logic dn);
    check({tag, ".valid"}, 32'(a_valid), 32'(v));
    check({tag, ".pc"},    32'(a_pc),    32'(pc));
    check({tag, ".addr"},  32'(a_addr),  32'(addr));
    check({tag, ".cnt"},   32'(a_cnt),   32'(cnt));
    check({tag, ".done"},  32'(a_done),  32'(dn));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; redirect_valid = 1'b0;
    redirect_target = '0; out_ready = 1'b1;
    @(negedge clk);
    tick();
    check_a("reset", 1'b0, 6'h00, 6'h00, 8'd0, 1'b0);
    check("reset.imm", 32'(a_imm), 32'h0);
    reset = 1'b0;
    tick();
    check_a("idle", 1'b0, 6'h00, 6'h00, 8'd0, 1'b0);

    start = 1'b1;
    tick();
    start = 1'b0;
    check_a("start", 1'b0, 6'h00, 6'h00, 8'd0, 1'b0);
    tick();
    check_a("cap0", 1'b1, 6'h00, 6'h01, 8'd1, 1'b0);
    tick();
    check_a("cap1", 1'b1, 6'h01, 6'h02, 8'd2, 1'b0);
    check("cap1.rd", 32'(a_rd), 32'h1);
    tick();
    check_a("cap2", 1'b1, 6'h02, 6'h03, 8'd3, 1'b0);
    check("cap2.rd",  32'(a_rd),  32'h2);
    check("cap2.imm", 32'(a_imm), 32'h0002);
    check("cap2.opc", 32'(a_opc), 32'h0);

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_a("stall", 1'b1, 6'h02, 6'h03, 8'd3, 1'b0);
      check("stall.imm", 32'(a_imm), 32'h0002);
    end
    out_ready = 1'b1;
    tick();
    check_a("release", 1'b1, 6'h03, 6'h04, 8'd4, 1'b0);
    check("release.rd", 32'(a_rd), 32'h3);

    redirect_valid = 1'b1; redirect_target = 6'h01;
    tick();
    redirect_valid = 1'b0;
    check_a("flush", 1'b0, 6'h03, 6'h01, 8'd4, 1'b0);
    tick();
    check_a("redir1", 1'b1, 6'h01, 6'h02, 8'd5, 1'b0);
    check("redir1.rd",  32'(a_rd),  32'h1);
    check("redir1.imm", 32'(a_imm), 32'h0001);
    tick();
    check_a("redir2", 1'b1, 6'h02, 6'h03, 8'd6, 1'b0);
    tick();
    check_a("redir3", 1'b1, 6'h03, 6'h04, 8'd7, 1'b0);
    tick();
    check_a("last", 1'b1, 6'h04, 6'h05, 8'd8, 1'b1);
    check("last.rd", 32'(a_rd), 32'h4);

    out_ready = 1'b0;
    tick();
    check_a("done_hold", 1'b1, 6'h04, 6'h05, 8'd8, 1'b1);
    out_ready = 1'b1;
    tick();
    check_a("done_drain", 1'b0, 6'h04, 6'h05, 8'd8, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_a("done_start", 1'b0, 6'h04, 6'h05, 8'd8, 1'b1);

    redirect_valid = 1'b1; redirect_target = 6'h00;
    tick();
    redirect_valid = 1'b0;
    check_a("done_redir", 1'b0, 6'h04, 6'h00, 8'd8, 1'b0);
    tick();
    check_a("rerun0", 1'b1, 6'h00, 6'h01, 8'd9, 1'b0);

    // Wrap run: start, then redirect to the top word in the first RUN cycle.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("w.reset.valid", 32'(b_valid), 32'h0);
    check("w.reset.cnt",   32'(b_cnt),   32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    redirect_valid = 1'b1; redirect_target = 6'h3F;
    tick();
    redirect_valid = 1'b0;
    check("w.flush.valid", 32'(b_valid), 32'h0);
    check("w.flush.addr",  32'(b_addr),  32'h3F);
    check("w.flush.cnt",   32'(b_cnt),   32'h0);
    tick();
    check("w.c3f.pc",   32'(b_pc),   32'h3F);
    check("w.c3f.imm",  32'(b_imm),  32'h0);
    check("w.c3f.addr", 32'(b_addr), 32'h00);
    tick();
    check("w.c00.pc",   32'(b_pc),   32'h00);
    check("w.c00.done", 32'(b_done), 32'h0);
    tick();
    check("w.c01.pc",   32'(b_pc),   32'h01);
    check("w.c01.imm",  32'(b_imm),  32'h0001);
    tick();
    check("w.c02.pc",   32'(b_pc),   32'h02);
    check("w.c02.rd",   32'(b_rd),   32'h2);
    check("w.c02.done", 32'(b_done), 32'h1);
    check("w.c02.cnt",  32'(b_cnt),  32'h4);
    check("w.c02.addr", 32'(b_addr), 32'h03);
    check_a("w.other", 1'b1, 6'h02, 6'h03, 8'd4, 1'b0);
    tick();
    check("w.after.valid", 32'(b_valid), 32'h0);
    check("w.after.cnt",   32'(b_cnt),   32'h4);
    check_a("w.other2", 1'b1, 6'h03, 6'h04, 8'd5, 1'b0);

    // Reset in the middle of a stall drops the held instruction at once.
    out_ready = 1'b0;
    tick();
    check_a("pre_rst_stall", 1'b1, 6'h03, 6'h04, 8'd5, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    check_a("mid_rst", 1'b0, 6'h00, 6'h00, 8'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_a("post_rst_idle", 1'b0, 6'h00, 6'h00, 8'd0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
